// File: rtl/game_ctrl_pkg.sv
// Shared encodings for the Connect-4 game sequencer: FSM states, datapath
// action codes and the pending-command register.
package game_ctrl_pkg;

  typedef enum logic [2:0] {
    S_RESET = 3'd0,
    S_CLEAR = 3'd1,
    S_GAP   = 3'd2,
    S_IDLE  = 3'd3,
    S_MOVE  = 3'd4,
    S_CHECK = 3'd5,
    S_OVER  = 3'd6
  } state_t;

  localparam logic [1:0] KR_REDRAW = 2'b00;
  localparam logic [1:0] KR_RIGHT  = 2'b01;
  localparam logic [1:0] KR_LEFT   = 2'b10;
  localparam logic [1:0] KR_DROP   = 2'b11;

  typedef enum logic [2:0] {
    CMD_NONE     = 3'd0,
    CMD_NEW_GAME = 3'd1,
    CMD_DROP     = 3'd2,
    CMD_LEFT     = 3'd3,
    CMD_RIGHT    = 3'd4
  } cmd_t;

  // Datapath action code for a player move command.
  function automatic logic [1:0] cmd_code(input cmd_t c);
    case (c)
      CMD_DROP:  cmd_code = KR_DROP;
      CMD_LEFT:  cmd_code = KR_LEFT;
      CMD_RIGHT: cmd_code = KR_RIGHT;
      default:   cmd_code = KR_REDRAW;
    endcase
  endfunction

endpackage

// File: rtl/key_edge.sv
// One-bit rising-edge detector; a held key yields a single-cycle event.
module key_edge (
  input  logic clk,
  input  logic reset,
  input  logic key,
  output logic rise_c
);

  logic prev_q;

  always_ff @(posedge clk) begin
    if (reset) prev_q <= 1'b0;
    else       prev_q <= key;
  end

  assign rise_c = key & ~prev_q;

endmodule

// File: rtl/game_controller.sv
// Sequencer turning player key presses into Connect-4 datapath handshakes,
// with inter-action gap, post-drop winner check and handshake timeout.
module game_controller #(
  parameter int unsigned GAP_CYCLES = 2,
  parameter int unsigned TIMEOUT    = 1048575
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_left,
  input  logic       key_right,
  input  logic       key_drop,
  input  logic       key_new_game,
  input  logic       actionComplete,
  input  logic       resetComplete,
  input  logic       wCheckComplete,
  input  logic       gameOver,
  output logic       execute,
  output logic [1:0] keyRead,
  output logic       resetGame,
  output logic       winnerCheck,
  output logic       busy,
  output logic       fault,
  output logic [2:0] state_dbg
);
  import game_ctrl_pkg::*;

  localparam int unsigned GW = 4;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
  localparam logic [TW-1:0] T_LAST   = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] T_MAX    = TW'(TIMEOUT);

  state_t        state_q, state_n;
  cmd_t          pend_q, pend_n;
  logic          redraw_q, redraw_n;
  logic [1:0]    kr_n;
  logic          fault_n;
  logic [GW-1:0] gcnt_q, gcnt_n;
  logic [TW-1:0] tcnt_q, tcnt_n;
  logic          pend_clr;
  logic          timeout_c;
  logic          ev_left, ev_right, ev_drop, ev_new;

  key_edge u_edge_left  (.clk(clk), .reset(reset), .key(key_left),     .rise_c(ev_left));
  key_edge u_edge_right (.clk(clk), .reset(reset), .key(key_right),    .rise_c(ev_right));
  key_edge u_edge_drop  (.clk(clk), .reset(reset), .key(key_drop),     .rise_c(ev_drop));
  key_edge u_edge_new   (.clk(clk), .reset(reset), .key(key_new_game), .rise_c(ev_new));

  assign timeout_c = (tcnt_q >= T_LAST);

  // Next state, pending command and counters
  always_comb begin
    state_n  = state_q;
    pend_n   = pend_q;
    redraw_n = redraw_q;
    kr_n     = keyRead;
    fault_n  = fault;
    pend_clr = 1'b0;

    case (state_q)
      S_RESET: state_n = S_CLEAR;
      S_CLEAR: begin
        if (resetComplete) begin
          state_n  = S_GAP;
          redraw_n = 1'b1;
        end else if (timeout_c) begin
          state_n = S_GAP;
          fault_n = 1'b1;
        end
      end
      S_GAP: begin
        if (gcnt_q >= GAP_LAST) begin
          if (redraw_q) begin
            state_n  = S_MOVE;
            kr_n     = KR_REDRAW;
            redraw_n = 1'b0;
          end else begin
            state_n = S_IDLE;
          end
        end
      end
      S_IDLE: begin
        if (pend_q == CMD_NEW_GAME) begin
          state_n  = S_CLEAR;
          pend_clr = 1'b1;
        end else if (pend_q != CMD_NONE) begin
          state_n  = S_MOVE;
          kr_n     = cmd_code(pend_q);
          pend_clr = 1'b1;
        end
      end
      S_MOVE: begin
        if (actionComplete) begin
          state_n = (keyRead == KR_DROP) ? S_CHECK : S_GAP;
        end else if (timeout_c) begin
          state_n = S_GAP;
          fault_n = 1'b1;
        end
      end
      S_CHECK: begin
        if (wCheckComplete) begin
          state_n = gameOver ? S_OVER : S_GAP;
        end else if (timeout_c) begin
          state_n = S_GAP;
          fault_n = 1'b1;
        end
      end
      S_OVER: begin
        if (pend_q == CMD_NEW_GAME) begin
          state_n  = S_CLEAR;
          pend_clr = 1'b1;
        end
      end
      default: state_n = S_RESET;
    endcase

    // New game always wins; other keys only fill an empty slot outside S_OVER
    if (ev_new) begin
      pend_n = CMD_NEW_GAME;
    end else if (pend_clr) begin
      pend_n = CMD_NONE;
    end else if (pend_q == CMD_NONE && state_q != S_OVER) begin
      if (ev_drop)       pend_n = CMD_DROP;
      else if (ev_left)  pend_n = CMD_LEFT;
      else if (ev_right) pend_n = CMD_RIGHT;
    end

    if (state_n == S_CLEAR && state_q != S_CLEAR) fault_n = 1'b0;

    gcnt_n = (state_n == S_GAP && state_q == S_GAP) ? gcnt_q + GW'(1) : '0;

    if (state_n != state_q)  tcnt_n = '0;
    else if (tcnt_q == T_MAX) tcnt_n = tcnt_q;
    else                      tcnt_n = tcnt_q + TW'(1);
  end

  // State register with outputs decoded from the next state
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_RESET;
      pend_q      <= CMD_NONE;
      redraw_q    <= 1'b0;
      gcnt_q      <= '0;
      tcnt_q      <= '0;
      execute     <= 1'b0;
      keyRead     <= KR_REDRAW;
      resetGame   <= 1'b0;
      winnerCheck <= 1'b0;
      busy        <= 1'b1;
      fault       <= 1'b0;
    end else begin
      state_q     <= state_n;
      pend_q      <= pend_n;
      redraw_q    <= redraw_n;
      gcnt_q      <= gcnt_n;
      tcnt_q      <= tcnt_n;
      execute     <= (state_n == S_CLEAR) || (state_n == S_MOVE);
      keyRead     <= kr_n;
      resetGame   <= (state_n == S_CLEAR);
      winnerCheck <= (state_n == S_CHECK);
      busy        <= !((state_n == S_IDLE) || (state_n == S_OVER));
      fault       <= fault_n;
    end
  end

  assign state_dbg = state_q;

endmodule

// File: tb/tb_game_controller.sv
// Scoreboard bench for game_controller: stimulus queues expected datapath
// requests, a negedge monitor pops and compares each strobe rising edge.
module tb_game_controller;
  import game_ctrl_pkg::*;

  localparam int GAP = 2;
  localparam int TMO = 15;
  localparam int K_CLEAR = 0;
  localparam int K_MOVE  = 1;
  localparam int K_CHECK = 2;

  typedef struct {
    int         kind;
    logic [1:0] kr;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       key_left = 1'b0, key_right = 1'b0, key_drop = 1'b0, key_new_game = 1'b0;
  logic       actionComplete = 1'b0, resetComplete = 1'b0, wCheckComplete = 1'b0, gameOver = 1'b0;
  logic       execute, resetGame, winnerCheck, busy, fault;
  logic [1:0] keyRead;
  logic [2:0] state_dbg;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass = 0;

  game_controller #(.GAP_CYCLES(GAP), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .key_left(key_left), .key_right(key_right), .key_drop(key_drop), .key_new_game(key_new_game),
    .actionComplete(actionComplete), .resetComplete(resetComplete),
    .wCheckComplete(wCheckComplete), .gameOver(gameOver),
    .execute(execute), .keyRead(keyRead), .resetGame(resetGame), .winnerCheck(winnerCheck),
    .busy(busy), .fault(fault), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic push(input int kind, input logic [1:0] kr);
    exp_t e;
    e.kind = kind;
    e.kr   = kr;
    q.push_back(e);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_state(input string name, input int s, input int budget);
    int n = 0;
    while (int'(state_dbg) != s && n < budget) begin
      tick();
      n++;
    end
    chk(name, int'(state_dbg), s);
  endtask

  task automatic wait_exec(input string name, input int budget);
    int n = 0;
    while (execute !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    chk(name, int'(execute), 1);
  endtask

  task automatic finish_action(input string name, input int hold);
    repeat (hold - 1) tick();
    actionComplete = 1'b1;
    tick();
    actionComplete = 1'b0;
    chk(name, int'(execute), 0);
  endtask

  task automatic finish_check(input string name, input int hold, input logic go);
    repeat (hold - 1) tick();
    wCheckComplete = 1'b1;
    gameOver = go;
    tick();
    wCheckComplete = 1'b0;
    gameOver = 1'b0;
    chk({name, "_wc_low"}, int'(winnerCheck), 0);
    chk({name, "_state"}, int'(state_dbg), go ? int'(S_OVER) : int'(S_GAP));
  endtask

  // Called with S_CLEAR active; completes it and the forced redraw
  task automatic run_clear(input string name, input int hold);
    push(K_MOVE, KR_REDRAW);
    repeat (hold - 1) tick();
    resetComplete = 1'b1;
    tick();
    resetComplete = 1'b0;
    chk({name, "_rg_low"}, int'(resetGame), 0);
    wait_exec({name, "_redraw"}, 20);
    chk({name, "_redraw_kr"}, int'(keyRead), int'(KR_REDRAW));
    finish_action({name, "_redraw_done"}, 1);
    wait_state({name, "_idle"}, int'(S_IDLE), 20);
  endtask

  // Monitor: each strobe rising edge must match the next queued request
  int   gap = 100;
  logic prev_ex = 1'b0, prev_wc = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      gap = 100;
      prev_ex = 1'b0;
      prev_wc = 1'b0;
    end else begin
      if (execute && !prev_ex) begin
        if (q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_exec: got keyRead=%0d resetGame=%0d, required no action", keyRead, resetGame);
        end else begin
          e = q.pop_front();
          chk("mon_kind", resetGame ? K_CLEAR : K_MOVE, e.kind);
          if (e.kind == K_MOVE) chk("mon_keyRead", int'(keyRead), int'(e.kr));
          n_checks++;
          if (gap >= GAP) n_pass++;
          else $display("FAIL exec_gap: got %0d low cycles, required at least %0d", gap, GAP);
        end
      end
      if (winnerCheck && !prev_wc) begin
        if (q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_check: got winnerCheck=1, required no request");
        end else begin
          e = q.pop_front();
          chk("mon_check_kind", K_CHECK, e.kind);
        end
      end
      gap = execute ? 0 : gap + 1;
      prev_ex = execute;
      prev_wc = winnerCheck;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end

  initial begin
    int hi;
    // Reset state
    repeat (3) tick();
    chk("rst_state", int'(state_dbg), int'(S_RESET));
    chk("rst_execute", int'(execute), 0);
    chk("rst_resetGame", int'(resetGame), 0);
    chk("rst_winnerCheck", int'(winnerCheck), 0);
    chk("rst_keyRead", int'(keyRead), 0);
    chk("rst_busy", int'(busy), 1);
    chk("rst_fault", int'(fault), 0);

    // Power-up clear with a 10-cycle resetComplete latency
    push(K_CLEAR, 2'b00);
    push(K_MOVE, KR_REDRAW);
    reset = 1'b0;
    tick();
    chk("clr_state", int'(state_dbg), int'(S_CLEAR));
    hi = 0;
    for (int i = 0; i < 10; i++) begin
      if (execute && resetGame) hi++;
      if (i < 9) tick();
    end
    resetComplete = 1'b1;
    tick();
    resetComplete = 1'b0;
    chk("clr_high_cycles", hi, 10);
    chk("clr_exec_low", int'(execute), 0);
    chk("clr_rg_low", int'(resetGame), 0);
    tick();
    chk("gap_2nd_low", int'(execute), 0);
    tick();
    chk("redraw_exec", int'(execute), 1);
    chk("redraw_kr", int'(keyRead), int'(KR_REDRAW));
    finish_action("redraw_done", 3);
    wait_state("idle0", int'(S_IDLE), 20);
    chk("idle_busy", int'(busy), 0);

    // Right pulse, then held left yields exactly one left action
    push(K_MOVE, KR_RIGHT);
    push(K_MOVE, KR_LEFT);
    key_right = 1'b1;
    tick();
    key_right = 1'b0;
    chk("right_pending_exec", int'(execute), 0);
    tick();
    chk("right_exec", int'(execute), 1);
    chk("right_kr", int'(keyRead), int'(KR_RIGHT));
    finish_action("right_done", 2);
    key_left = 1'b1;
    wait_exec("left_exec", 20);
    chk("left_kr", int'(keyRead), int'(KR_LEFT));
    finish_action("left_done", 2);
    repeat (12) tick();
    key_left = 1'b0;
    chk("left_once_state", int'(state_dbg), int'(S_IDLE));

    // Drop and left on the same edge: drop wins, left discarded
    push(K_MOVE, KR_DROP);
    push(K_CHECK, 2'b00);
    key_drop = 1'b1;
    key_left = 1'b1;
    wait_exec("dropA_exec", 20);
    key_drop = 1'b0;
    key_left = 1'b0;
    chk("dropA_kr", int'(keyRead), int'(KR_DROP));
    finish_action("dropA_done", 2);
    chk("dropA_check_state", int'(state_dbg), int'(S_CHECK));
    chk("dropA_wc", int'(winnerCheck), 1);
    finish_check("dropA_chk", 2, 1'b0);
    wait_state("dropA_idle", int'(S_IDLE), 20);
    repeat (5) tick();
    chk("dropA_no_left", int'(state_dbg), int'(S_IDLE));

    // Drop with a winner: S_OVER ignores left, new game restarts
    push(K_MOVE, KR_DROP);
    push(K_CHECK, 2'b00);
    key_drop = 1'b1;
    wait_exec("dropB_exec", 20);
    key_drop = 1'b0;
    finish_action("dropB_done", 1);
    finish_check("dropB_chk", 3, 1'b1);
    chk("over_busy", int'(busy), 0);
    key_left = 1'b1;
    tick();
    key_left = 1'b0;
    repeat (5) tick();
    chk("over_ignores_left", int'(state_dbg), int'(S_OVER));
    chk("over_exec", int'(execute), 0);
    push(K_CLEAR, 2'b00);
    key_new_game = 1'b1;
    wait_exec("ng_exec", 20);
    key_new_game = 1'b0;
    chk("ng_resetGame", int'(resetGame), 1);
    run_clear("ng", 4);

    // New game pressed during the winner scan
    push(K_MOVE, KR_DROP);
    push(K_CHECK, 2'b00);
    push(K_CLEAR, 2'b00);
    key_drop = 1'b1;
    wait_exec("dropC_exec", 20);
    key_drop = 1'b0;
    finish_action("dropC_done", 1);
    key_new_game = 1'b1;
    tick();
    key_new_game = 1'b0;
    chk("dropC_still_check", int'(state_dbg), int'(S_CHECK));
    finish_check("dropC_chk", 2, 1'b1);
    tick();
    chk("dropC_clear", int'(state_dbg), int'(S_CLEAR));
    chk("dropC_rg", int'(resetGame), 1);
    run_clear("dropC", 2);

    // Timeout: actionComplete never arrives
    push(K_MOVE, KR_RIGHT);
    key_right = 1'b1;
    wait_exec("to_exec", 20);
    key_right = 1'b0;
    hi = 0;
    while (execute && hi < 40) begin
      hi++;
      tick();
    end
    chk("to_exec_cycles", hi, TMO);
    chk("to_fault", int'(fault), 1);
    chk("to_state_gap", int'(state_dbg), int'(S_GAP));
    wait_state("to_idle", int'(S_IDLE), 20);
    chk("to_fault_sticky", int'(fault), 1);
    push(K_CLEAR, 2'b00);
    key_new_game = 1'b1;
    wait_exec("to_ng_exec", 20);
    key_new_game = 1'b0;
    chk("to_fault_cleared", int'(fault), 0);
    run_clear("to_ng", 3);

    // Reset in the middle of a move
    push(K_MOVE, KR_LEFT);
    key_left = 1'b1;
    wait_exec("rm_exec", 20);
    key_left = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    chk("rm_exec", int'(execute), 0);
    chk("rm_rg", int'(resetGame), 0);
    chk("rm_wc", int'(winnerCheck), 0);
    chk("rm_busy", int'(busy), 1);
    chk("rm_state", int'(state_dbg), int'(S_RESET));
    tick();
    push(K_CLEAR, 2'b00);
    reset = 1'b0;
    wait_exec("rm_clear_exec", 10);
    chk("rm_clear_rg", int'(resetGame), 1);
    run_clear("rm", 2);

    repeat (3) tick();
    chk("queue_empty", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/game_controller.md
# game_controller

Top-level sequencer for the Connect-4 board datapath. It turns player key presses into the datapath's execute/keyRead/resetGame/winnerCheck handshakes, waiting for each completion flag. It inserts the mandatory execute-low gap between actions, runs a winner check after every drop, and halts play on game over until a new game is requested. It sits between the board key inputs and the datapath; it is the only driver of the datapath control inputs.

## Interface
- GAP_CYCLES, 2: cycles execute is held low between consecutive actions (legal range 1..15).
- TIMEOUT, 1048575: maximum cycles any handshake state may wait for its completion flag.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high; forces all state and outputs to reset values.
- key_left, key_right, key_drop, key_new_game  in  1 each  active-high button levels, already synchronised.
- actionComplete  in  1  datapath: cursor move/redraw/drop finished.
- resetComplete  in  1  datapath: board clear finished.
- wCheckComplete  in  1  datapath: winner scan finished.
- gameOver  in  1  datapath: a winner exists, sampled when wCheckComplete=1.
- execute  out  1  datapath action strobe, level, registered.
- keyRead  out  2  action code: 00 redraw, 01 right, 10 left, 11 drop.
- resetGame  out  1  board clear request, registered.
- winnerCheck  out  1  winner scan request, registered.
- busy  out  1  high in every state except S_IDLE and S_OVER.
- fault  out  1  sticky; a handshake timed out.
- state_dbg  out  3  current state encoding, for the HEX display.

## Operation
- States: S_RESET, S_CLEAR, S_GAP, S_IDLE, S_MOVE, S_CHECK, S_OVER.
- Key inputs are rising-edge detected against a registered previous level; holding a key produces exactly one event.
- A single pending-command register holds at most one command.
  - Events on the same edge: priority new_game > drop > left > right.
  - A new_game event always overwrites the pending command.
  - Other events are ignored if a command is already pending.
  - In S_OVER, only new_game is captured.
- S_RESET: one cycle, then S_CLEAR.
- S_CLEAR: drives execute=1 and resetGame=1 until resetComplete=1. Then goes to S_GAP with a redraw (00) queued as the forced next command.
- S_GAP: execute, resetGame and winnerCheck are all 0 for GAP_CYCLES cycles. Then:
  - to S_MOVE if a forced redraw is queued;
  - else to S_IDLE.
- S_IDLE: dispatches the pending command and clears the pending register.
  - new_game → S_CLEAR.
  - left, right or drop → S_MOVE with the matching keyRead code.
- S_MOVE: execute=1 with keyRead held constant until actionComplete=1. Then:
  - code 11 → S_CHECK;
  - any other code → S_GAP.
- S_CHECK: execute=0 and winnerCheck=1 until wCheckComplete=1. Then:
  - gameOver=1 → S_OVER;
  - else → S_GAP.
- S_OVER: all strobes low. A pending new_game → S_CLEAR.
- new_game during S_CLEAR, S_MOVE or S_CHECK is held pending; the current handshake always completes and is never aborted.
- Timeout:
  - A counter resets on entry to S_CLEAR, S_MOVE or S_CHECK and increments every cycle in those states.
  - Reaching TIMEOUT sets fault and forces S_GAP.
  - fault clears only on reset or on entry to S_CLEAR.
- A full column is not an error: the datapath returns actionComplete and the winner check still runs.

## Timing
- Reset values:
  - state S_RESET;
  - execute, resetGame, winnerCheck, fault = 0; keyRead = 00;
  - busy = 1;
  - pending register empty; previous-key registers = 0.
- All outputs are Moore, decoded from the registered state plus the command register. There are no combinational paths from inputs to outputs.
- Key first sampled high at edge k: pending is set at edge k, the state leaves S_IDLE at edge k+1, and execute is high from edge k+1.
- A completion flag sampled at edge m: the strobe is low from edge m.
- Between the end of one execute assertion and the next there are at least GAP_CYCLES low cycles.
- Drop to next key action: the S_MOVE handshake, then 1 cycle into S_CHECK, the scan, then GAP_CYCLES.
- Completion flags are ignored outside their own state.
- Reset mid-handshake drops all strobes at the next edge and restarts from S_RESET.
- Timeout counter width is $clog2(TIMEOUT+1). It saturates and never wraps.

## Structure
- Package game_ctrl_pkg holds:
  - the state encoding (3-bit localparams, values 0..6 in the order listed);
  - the keyRead codes KR_REDRAW, KR_RIGHT, KR_LEFT, KR_DROP;
  - the command encoding for the pending register.
- Sub-module key_edge: a one-bit rising-edge detector with a synchronous reset; instantiate it four times.
- FSM, pending register, gap counter and timeout counter live in game_controller.

## Test plan
- Reset, then resetComplete pulsed after 10 cycles → execute and resetGame are high for exactly those cycles; execute is low for 2 cycles; then execute=1 with keyRead=00 until actionComplete.
- From S_IDLE, pulse key_right, and hold key_left for 20 cycles after the first move completes → one 01 action, then exactly one 10 action, each separated by at least GAP_CYCLES low cycles.
- key_drop with actionComplete, then wCheckComplete=1 and gameOver=1 → winnerCheck=1 for one state, then S_OVER. key_left is then ignored. key_new_game → resetGame=1.
- key_drop and key_left rising on the same edge → keyRead=11 is issued and left is discarded. key_new_game during S_CHECK → S_CLEAR entered right after wCheckComplete, with no intermediate S_IDLE dispatch.
- TIMEOUT=15 with actionComplete never asserted → execute drops after 15 cycles, fault=1 and stays set. A later new game clears fault on S_CLEAR entry.
- Assert reset during S_MOVE → all strobes are 0 at the next edge, busy=1 and state_dbg=S_RESET.
